// File: rtl/uart_pkg.sv
// Shared constants and entry layout for the UART receive path.
package uart_pkg;
  localparam int UART_DW       = 8;
  localparam int UART_EW       = UART_DW + 1;
  localparam int UART_AW_DEF   = 4;
  localparam int UART_TMSB_DEF = 15;

  typedef struct packed {
    logic               err;
    logic [UART_DW-1:0] data;
  } uart_entry_t;
endpackage

// File: rtl/uart_fifo_mem.sv
// Flop-array storage for the receive FIFO: synchronous write, asynchronous read.
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int AW = UART_AW_DEF
) (
  input  logic               fclk,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [UART_EW-1:0] wdata,
  input  logic [AW-1:0]      raddr,
  output logic [UART_EW-1:0] rdata
);
  logic [UART_EW-1:0] mem [2**AW];

  // NOTE: storage has no reset; the pointers decide which entries are valid.
  always_ff @(posedge fclk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO with show-ahead read, level-threshold and idle-timeout interrupts.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int AW   = UART_AW_DEF,
  parameter int TMSB = UART_TMSB_DEF
) (
  input  logic               fclk,
  input  logic               rstn,
  input  logic               clear,
  input  logic               wr_vld,
  input  logic [UART_DW-1:0] wr_data,
  input  logic               wr_err,
  input  logic               rd_en,
  output logic [UART_DW-1:0] rd_data,
  output logic               rd_err,
  output logic               empty,
  output logic               full,
  output logic [AW:0]        level,
  input  logic [AW:0]        thresh,
  input  logic [TMSB:0]      tmo,
  output logic               irq_thresh,
  output logic               irq_tmo,
  output logic               ovf,
  input  logic               ovf_clr
);
  logic [AW:0]   wptr, rptr;
  logic [TMSB:0] tcnt;
  logic          wr_acc, rd_acc, wr_drop, tmo_hit;
  uart_entry_t   wentry, head;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign level = wptr - rptr;

  // A full FIFO still takes a write when a read frees a slot in the same cycle.
  assign wr_acc  = !clear && wr_vld && (!full || rd_en);
  assign rd_acc  = !clear && rd_en && !empty;
  assign wr_drop = !clear && wr_vld && !wr_acc;
  assign tmo_hit = (tmo != '0) && (tcnt == tmo);

  assign wentry = '{err: wr_err, data: wr_data};

  uart_fifo_mem #(.AW(AW)) u_mem (
    .fclk  (fclk),
    .we    (wr_acc),
    .waddr (wptr[AW-1:0]),
    .wdata (wentry),
    .raddr (rptr[AW-1:0]),
    .rdata (head)
  );

  // Masked while empty so stale storage never leaks onto the bus.
  assign rd_data    = empty ? '0 : head.data;
  assign rd_err     = empty ? 1'b0 : head.err;
  assign irq_thresh = (thresh != '0) && (level >= thresh);

  // NOTE: sequential state uses non-blocking assignments with an async active-low reset.
  always_ff @(posedge fclk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      ovf     <= 1'b0;
      irq_tmo <= 1'b0;
      tcnt    <= '0;
    end else if (clear) begin
      wptr    <= '0;
      rptr    <= '0;
      ovf     <= 1'b0;
      irq_tmo <= 1'b0;
      tcnt    <= '0;
    end else begin
      if (wr_acc) wptr <= wptr + 1'b1;
      if (rd_acc) rptr <= rptr + 1'b1;

      if (wr_drop)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;

      if (rd_acc || empty) irq_tmo <= 1'b0;
      else if (tmo_hit)    irq_tmo <= 1'b1;

      // Idle counter saturates so a long-stalled consumer cannot re-arm by wrapping.
      if (wr_acc || rd_acc || empty) tcnt <= '0;
      else if (tcnt != '1)           tcnt <= tcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed table, corner sequences, randomized traffic.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  localparam int AW    = 4;
  localparam int TMSB  = 15;
  localparam int DEPTH = 2**AW;
  localparam int CMAX  = 2**(TMSB+1) - 1;

  logic        fclk = 1'b0, rstn = 1'b0;
  logic        clear = 1'b0, wr_vld = 1'b0, wr_err = 1'b0, rd_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [7:0]  rd_data;
  logic        rd_err, empty, full, irq_thresh, irq_tmo, ovf;
  logic [AW:0] level;
  logic [AW:0] thresh = '0;
  logic [TMSB:0] tmo = '0;

  uart_rx_fifo #(.AW(AW), .TMSB(TMSB)) dut (
    .fclk(fclk), .rstn(rstn), .clear(clear), .wr_vld(wr_vld), .wr_data(wr_data),
    .wr_err(wr_err), .rd_en(rd_en), .rd_data(rd_data), .rd_err(rd_err), .empty(empty),
    .full(full), .level(level), .thresh(thresh), .tmo(tmo), .irq_thresh(irq_thresh),
    .irq_tmo(irq_tmo), .ovf(ovf), .ovf_clr(ovf_clr)
  );

  always #5 fclk = ~fclk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {err, byte} plus idle count and flags.
  logic [8:0] mq[$];
  bit m_ovf, m_irq;
  int m_cnt;

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_irq = 0; m_cnt = 0;
  endtask

  task automatic model_step();
    int  sz;
    bit  rd_ok, wr_ok, hit;
    if (clear) begin
      model_reset();
      return;
    end
    sz    = mq.size();
    rd_ok = rd_en && sz > 0;
    wr_ok = wr_vld && (sz < DEPTH || rd_en);
    hit   = (tmo != 0) && (m_cnt == int'(tmo));
    if (rd_ok || sz == 0) m_irq = 0;
    else if (hit)         m_irq = 1;
    if (wr_ok || rd_ok || sz == 0) m_cnt = 0;
    else if (m_cnt < CMAX)         m_cnt++;
    if (wr_vld && !wr_ok) m_ovf = 1;
    else if (ovf_clr)     m_ovf = 0;
    if (rd_ok) void'(mq.pop_front());
    if (wr_ok) mq.push_back({wr_err, wr_data});
  endtask

  function automatic logic [31:0] exp_bundle();
    int lv;
    logic [8:0] hd;
    bit ith;
    lv  = mq.size();
    hd  = (lv > 0) ? mq[0] : 9'h0;
    ith = (thresh != 0) && (lv >= int'(thresh));
    return {13'b0, hd[7:0], hd[8], lv == 0, lv == DEPTH, 5'(lv), ith, m_irq, m_ovf};
  endfunction

  function automatic logic [31:0] obs_bundle();
    return {13'b0, rd_data, rd_err, empty, full, level, irq_thresh, irq_tmo, ovf};
  endfunction

  task automatic step();
    model_step();
    @(posedge fclk);
    #1;
    check("model", obs_bundle(), exp_bundle());
  endtask

  task automatic idle_in();
    clear = 0; wr_vld = 0; wr_data = '0; wr_err = 0; rd_en = 0; ovf_clr = 0;
  endtask

  task automatic wr(input logic [7:0] d, input logic e);
    wr_vld = 1; wr_data = d; wr_err = e;
    step();
    idle_in();
  endtask

  task automatic rd();
    rd_en = 1;
    step();
    idle_in();
  endtask

  typedef struct {
    logic       clr, wv;
    logic [7:0] wd;
    logic       we, re, oc;
    logic [4:0] th;
    logic [4:0] e_lvl;
    logic [7:0] e_data;
    logic       e_err, e_empty, e_full, e_ovf, e_ith;
  } vec_t;

  function automatic vec_t mk(input logic wv, input logic [7:0] wd, input logic we,
                              input logic re, input logic [4:0] th, input logic [4:0] lvl,
                              input logic [7:0] dat, input logic er, input logic ith);
    vec_t v;
    v.clr = 0; v.wv = wv; v.wd = wd; v.we = we; v.re = re; v.oc = 0; v.th = th;
    v.e_lvl = lvl; v.e_data = dat; v.e_err = er; v.e_empty = (lvl == 0);
    v.e_full = (lvl == 5'd16); v.e_ovf = 0; v.e_ith = ith;
    return v;
  endfunction

  vec_t vt[18];
  int   n;
  int   p_wr, p_rd;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Test 1 rows (0-6) then threshold rows (7-17).
    vt[0]  = mk(1, 8'h55, 0, 0, 0, 1, 8'h55, 0, 0);
    vt[1]  = mk(0, 8'h00, 0, 0, 0, 1, 8'h55, 0, 0);
    vt[2]  = mk(1, 8'hA3, 1, 0, 0, 2, 8'h55, 0, 0);
    vt[3]  = mk(0, 8'h00, 0, 0, 0, 2, 8'h55, 0, 0);
    vt[4]  = mk(0, 8'h00, 0, 1, 0, 1, 8'hA3, 1, 0);
    vt[5]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
    vt[6]  = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);
    vt[7]  = mk(1, 8'h01, 0, 0, 4, 1, 8'h01, 0, 0);
    vt[8]  = mk(1, 8'h02, 0, 0, 4, 2, 8'h01, 0, 0);
    vt[9]  = mk(1, 8'h03, 0, 0, 4, 3, 8'h01, 0, 0);
    vt[10] = mk(1, 8'h04, 0, 0, 4, 4, 8'h01, 0, 1);
    vt[11] = mk(0, 8'h00, 0, 1, 4, 3, 8'h02, 0, 0);
    vt[12] = mk(1, 8'h05, 0, 0, 0, 4, 8'h02, 0, 0);
    vt[13] = mk(0, 8'h00, 0, 0, 0, 4, 8'h02, 0, 0);
    vt[14] = mk(0, 8'h00, 0, 1, 0, 3, 8'h03, 0, 0);
    vt[15] = mk(0, 8'h00, 0, 1, 0, 2, 8'h04, 0, 0);
    vt[16] = mk(0, 8'h00, 0, 1, 0, 1, 8'h05, 0, 0);
    vt[17] = mk(0, 8'h00, 0, 1, 0, 0, 8'h00, 0, 0);

    // Reset state
    model_reset();
    idle_in();
    repeat (3) @(posedge fclk);
    #1;
    check("reset_state", obs_bundle(), {13'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
    @(negedge fclk);
    rstn = 1;

    // Directed table
    for (int i = 0; i < 18; i++) begin
      clear = vt[i].clr; wr_vld = vt[i].wv; wr_data = vt[i].wd; wr_err = vt[i].we;
      rd_en = vt[i].re; ovf_clr = vt[i].oc; thresh = vt[i].th;
      step();
      check($sformatf("vec%0d", i),
            {13'b0, rd_data, rd_err, empty, full, level, irq_thresh, ovf},
            {13'b0, vt[i].e_data, vt[i].e_err, vt[i].e_empty, vt[i].e_full, vt[i].e_lvl,
             vt[i].e_ith, vt[i].e_ovf});
    end
    idle_in();
    thresh = '0;

    // Overflow: 16 writes then a dropped 0xFF
    for (int i = 0; i < 16; i++) wr(8'(i), 1'b0);
    wr(8'hFF, 1'b0);
    check("t2_full", {31'b0, full}, 32'd1);
    check("t2_level", level, 32'd16);
    check("t2_ovf", {31'b0, ovf}, 32'd1);
    for (int i = 0; i < 16; i++) begin
      check("t2_readback", rd_data, 32'(i));
      rd();
    end
    check("t2_empty", {31'b0, empty}, 32'd1);
    check("t2_ovf_sticky", {31'b0, ovf}, 32'd1);
    ovf_clr = 1;
    step();
    idle_in();
    check("t2_ovf_clr", {31'b0, ovf}, 32'd0);

    // Full with simultaneous read and write
    for (int i = 0; i < 16; i++) wr(8'h20 + 8'(i), 1'b0);
    wr_vld = 1; wr_data = 8'hEE; rd_en = 1;
    step();
    idle_in();
    check("t3_ovf", {31'b0, ovf}, 32'd0);
    check("t3_level", level, 32'd16);
    check("t3_head", rd_data, 32'h21);
    repeat (15) rd();
    check("t3_last", rd_data, 32'hEE);
    rd();
    check("t3_empty", {31'b0, empty}, 32'd1);

    // Idle timeout
    tmo = 16'd10;
    wr(8'h11, 1'b0);
    n = 1;
    step();
    while (!irq_tmo && n < 40) begin
      step();
      n++;
    end
    check("t5_latency", n, 32'd11);
    repeat (3) step();
    check("t5_hold", {31'b0, irq_tmo}, 32'd1);
    rd();
    check("t5_rd_clears", {31'b0, irq_tmo}, 32'd0);
    wr(8'h12, 1'b0);
    repeat (4) step();
    wr(8'h13, 1'b0);
    repeat (10) step();
    check("t5_restart_early", {31'b0, irq_tmo}, 32'd0);
    step();
    check("t5_restart_fire", {31'b0, irq_tmo}, 32'd1);
    rd();
    check("t5_rd_clears2", {31'b0, irq_tmo}, 32'd0);
    rd();
    tmo = '0;

    // Clear with concurrent write
    for (int i = 0; i < 5; i++) wr(8'h40 + 8'(i), 1'b1);
    clear = 1; wr_vld = 1; wr_data = 8'h77;
    step();
    idle_in();
    check("t6_clear", {27'b0, empty, level, ovf, irq_tmo},
          {27'b0, 1'b1, 5'd0, 1'b0, 1'b0});

    // Asynchronous reset mid-traffic
    wr(8'h01, 1'b0);
    wr(8'h02, 1'b1);
    wr_vld = 1; wr_data = 8'h03;
    @(posedge fclk);
    #2;
    rstn = 0;
    #1;
    check("t6_async_rst", obs_bundle(), {13'b0, 8'h00, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0});
    model_reset();
    idle_in();
    @(negedge fclk);
    rstn = 1;
    step();

    // Randomized traffic
    p_wr = 55; p_rd = 45;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        p_wr   = $urandom_range(5, 95);
        p_rd   = $urandom_range(5, 95);
        thresh = 5'($urandom_range(0, 16));
        tmo    = 16'($urandom_range(0, 15));
      end
      wr_vld  = ($urandom_range(0, 99) < p_wr);
      rd_en   = ($urandom_range(0, 99) < p_rd);
      wr_data = 8'($urandom);
      wr_err  = 1'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      clear   = ($urandom_range(0, 299) == 0);
      step();
    end
    idle_in();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
